// File: rtl/fft8_pkg.sv
// fft8_pkg: shared types and constants for the streaming 8-point FFT.
// FSM states, bit reversal, twiddle constant and per-stage butterfly maps.
package fft8_pkg;

  typedef enum logic [2:0] {
    S_LOAD,
    S_BF1,
    S_BF2,
    S_BF3,
    S_OUT
  } state_e;

  // Distance between the two legs of a butterfly, per stage.
  localparam logic [2:0] BF_SPAN [3] = '{3'd1, 3'd2, 3'd4};

  // Lower-leg buffer slot of each of the four butterflies, per stage.
  localparam logic [2:0] BF_LO [3][4] = '{
    '{3'd0, 3'd2, 3'd4, 3'd6},
    '{3'd0, 3'd1, 3'd4, 3'd5},
    '{3'd0, 3'd1, 3'd2, 3'd3}
  };

  // Twiddle exponent k of W^k for each butterfly, per stage.
  localparam logic [1:0] BF_TW [3][4] = '{
    '{2'd0, 2'd0, 2'd0, 2'd0},
    '{2'd0, 2'd2, 2'd0, 2'd2},
    '{2'd0, 2'd1, 2'd2, 2'd3}
  };

  function automatic logic [2:0] bitrev3(input logic [2:0] n);
    return {n[0], n[1], n[2]};
  endfunction

  // round(0.70710678 * 2^frac) in integer arithmetic.
  function automatic int calc_c(input int frac);
    longint num;
    num = (longint'(1) << frac) * 64'sd70710678 + 64'sd50000000;
    return int'(num / 64'sd100000000);
  endfunction

endpackage

// File: rtl/fft8_if.sv
// fft8_if: sample-in / bin-out valid-ready bundle for fft8_stream.
// slave = FFT side, master = producer/consumer side.
interface fft8_if
  import fft8_pkg::*;
#(
  parameter int W = 16
);
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] in_real;
  logic signed [W-1:0] in_imag;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] out_real;
  logic signed [W-1:0] out_imag;
  logic [2:0]          out_index;
  logic                out_last;
  logic                out_ovf;

  modport slave (
    input  in_valid, in_real, in_imag, out_ready,
    output in_ready, out_valid, out_real, out_imag,
    output out_index, out_last, out_ovf
  );

  modport master (
    output in_valid, in_real, in_imag, out_ready,
    input  in_ready, out_valid, out_real, out_imag,
    input  out_index, out_last, out_ovf
  );
endinterface

// File: rtl/fft8_bfly.sv
// fft8_bfly: combinational radix-2 butterfly, y0 = a + b*W^tw, y1 = a - b*W^tw.
// Ports: a/b legs in, tw 0..3, y0/y1 out, ovf on any wrapped add. Macro FFT8_SCALE_EN halves outputs.
module fft8_bfly
  import fft8_pkg::*;
#(
  parameter int W    = 16,
  parameter int FRAC = 8
) (
  input  logic signed [W-1:0] a_re,
  input  logic signed [W-1:0] a_im,
  input  logic signed [W-1:0] b_re,
  input  logic signed [W-1:0] b_im,
  input  logic [1:0]          tw,
  output logic signed [W-1:0] y0_re,
  output logic signed [W-1:0] y0_im,
  output logic signed [W-1:0] y1_re,
  output logic signed [W-1:0] y1_im,
  output logic                ovf
);

  localparam logic [W-1:0] C = W'(calc_c(FRAC));

  // Sign-magnitude multiply by C: truncates toward zero.
  function automatic logic signed [W-1:0] cmul(
    input logic signed [W-1:0] a
  );
    logic [W-1:0]   mag;
    logic [2*W-1:0] p;
    logic [W-1:0]   t;
    mag = a[W-1] ? -a : a;
    p   = {{W{1'b0}}, mag} * {{W{1'b0}}, C};
    t   = W'(p >> FRAC);
    return a[W-1] ? -t : t;
  endfunction

  logic signed [W:0]   sum_x, dif_x;
  logic signed [W-1:0] sum_w, dif_w;
  logic signed [W-1:0] h_re, h_im;
  logic                tw_ovf;
  logic signed [W:0]   s0r, s0i, s1r, s1i;

  always_comb begin
    sum_x  = {b_re[W-1], b_re} + {b_im[W-1], b_im};
    dif_x  = {b_im[W-1], b_im} - {b_re[W-1], b_re};
    sum_w  = sum_x[W-1:0];
    dif_w  = dif_x[W-1:0];
    h_re   = b_re;
    h_im   = b_im;
    tw_ovf = 1'b0;
    unique case (tw)
      2'd0: begin
        h_re = b_re;
        h_im = b_im;
      end
      2'd1: begin
        h_re   = cmul(sum_w);
        h_im   = cmul(dif_w);
        tw_ovf = (sum_x[W] ^ sum_x[W-1])
               | (dif_x[W] ^ dif_x[W-1]);
      end
      2'd2: begin
        // times -j: swap and negate, no multiplier
        h_re = b_im;
        h_im = -b_re;
      end
      2'd3: begin
        h_re   = cmul(dif_w);
        h_im   = -cmul(sum_w);
        tw_ovf = (sum_x[W] ^ sum_x[W-1])
               | (dif_x[W] ^ dif_x[W-1]);
      end
    endcase

    s0r = {a_re[W-1], a_re} + {h_re[W-1], h_re};
    s0i = {a_im[W-1], a_im} + {h_im[W-1], h_im};
    s1r = {a_re[W-1], a_re} - {h_re[W-1], h_re};
    s1i = {a_im[W-1], a_im} - {h_im[W-1], h_im};

    ovf = tw_ovf
        | (s0r[W] ^ s0r[W-1]) | (s0i[W] ^ s0i[W-1])
        | (s1r[W] ^ s1r[W-1]) | (s1i[W] ^ s1i[W-1]);

`ifdef FFT8_SCALE_EN
    y0_re = W'(s0r >>> 1);
    y0_im = W'(s0i >>> 1);
    y1_re = W'(s1r >>> 1);
    y1_im = W'(s1i >>> 1);
`else
    y0_re = s0r[W-1:0];
    y0_im = s0i[W-1:0];
    y1_re = s1r[W-1:0];
    y1_im = s1i[W-1:0];
`endif
  end

endmodule

// File: rtl/fft8_stream.sv
// fft8_stream: streaming 8-point DIT FFT, load 8 samples, 3 butterfly passes, unload 8 bins.
// Ports: clk, rst (sync, high), io (fft8_if.slave). Macro FFT8_SCALE_EN scales each stage by 1/2.
module fft8_stream
  import fft8_pkg::*;
#(
  parameter int W    = 16,
  parameter int FRAC = 8
) (
  input  logic  clk,
  input  logic  rst,
  fft8_if.slave io
);

  state_e              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [2:0]          idx_q, idx_d;
  logic                ovf_q, ovf_d;
  logic signed [W-1:0] re_q [8];
  logic signed [W-1:0] im_q [8];
  logic signed [W-1:0] re_d [8];
  logic signed [W-1:0] im_d [8];

  logic [1:0]          stg;
  logic [2:0]          lo_idx [4];
  logic [2:0]          hi_idx [4];
  logic [1:0]          tw [4];
  logic signed [W-1:0] a_re [4], a_im [4];
  logic signed [W-1:0] b_re [4], b_im [4];
  logic signed [W-1:0] y0_re [4], y0_im [4];
  logic signed [W-1:0] y1_re [4], y1_im [4];
  logic [3:0]          bf_ovf;

  logic load_st, out_st, in_fire, out_fire;

  assign load_st  = (state_q == S_LOAD);
  assign out_st   = (state_q == S_OUT);
  assign in_fire  = load_st & io.in_valid;
  assign out_fire = out_st & io.out_ready;

  // Route buffer slots to the four shared butterflies.
  always_comb begin
    case (state_q)
      S_BF2:   stg = 2'd1;
      S_BF3:   stg = 2'd2;
      default: stg = 2'd0;
    endcase
    for (int b = 0; b < 4; b++) begin
      lo_idx[b] = BF_LO[stg][b];
      hi_idx[b] = BF_LO[stg][b] + BF_SPAN[stg];
      tw[b]     = BF_TW[stg][b];
      a_re[b]   = re_q[lo_idx[b]];
      a_im[b]   = im_q[lo_idx[b]];
      b_re[b]   = re_q[hi_idx[b]];
      b_im[b]   = im_q[hi_idx[b]];
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_bf
    fft8_bfly #(.W(W), .FRAC(FRAC)) u_bf (
      .a_re  (a_re[g]),
      .a_im  (a_im[g]),
      .b_re  (b_re[g]),
      .b_im  (b_im[g]),
      .tw    (tw[g]),
      .y0_re (y0_re[g]),
      .y0_im (y0_im[g]),
      .y1_re (y1_re[g]),
      .y1_im (y1_im[g]),
      .ovf   (bf_ovf[g])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q;
    re_d    = re_q;
    im_d    = im_q;
    unique case (state_q)
      S_LOAD: begin
        if (in_fire) begin
          // bit-reversed placement lets the passes run in place
          re_d[bitrev3(cnt_q)] = io.in_real;
          im_d[bitrev3(cnt_q)] = io.in_imag;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd0) ovf_d = 1'b0;
          if (cnt_q == 3'd7) state_d = S_BF1;
        end
      end
      S_BF1, S_BF2, S_BF3: begin
        for (int b = 0; b < 4; b++) begin
          re_d[lo_idx[b]] = y0_re[b];
          im_d[lo_idx[b]] = y0_im[b];
          re_d[hi_idx[b]] = y1_re[b];
          im_d[hi_idx[b]] = y1_im[b];
        end
        ovf_d = ovf_q | (|bf_ovf);
        if (state_q == S_BF1)      state_d = S_BF2;
        else if (state_q == S_BF2) state_d = S_BF3;
        else                       state_d = S_OUT;
      end
      S_OUT: begin
        if (out_fire) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_LOAD;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LOAD;
      cnt_q   <= '0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    re_q <= re_d;
    im_q <= im_d;
  end

  always_comb begin
    io.in_ready  = load_st;
    io.out_valid = out_st;
    io.out_index = idx_q;
    io.out_last  = out_st & (idx_q == 3'd7);
    io.out_ovf   = out_st & ovf_q;
    io.out_real  = '0;
    io.out_imag  = '0;
    if (out_st) begin
      io.out_real = re_q[idx_q];
      io.out_imag = im_q[idx_q];
    end
  end

endmodule

// File: tb/tb_fft8_stream.sv
// tb_fft8_stream: table vectors, latency/reset sequences and random stress
// against an integer reference FFT kept in the bench.
module tb_fft8_stream;
  localparam int W = 16;
  localparam int FRAC = 8;
  localparam int CC = 181;
`ifdef FFT8_SCALE_EN
  localparam int SCALED = 1;
`else
  localparam int SCALED = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft8_if #(.W(W)) bus ();

  fft8_stream #(.W(W), .FRAC(FRAC)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  int checks = 0;
  int errors = 0;

  int sr [64];
  int si [64];
  int gt_re [$];
  int gt_im [$];
  int gt_ov [$];

  typedef struct packed {
    logic [7:0][15:0] xr;
    logic [7:0][15:0] xi;
    logic [7:0][15:0] er;
    logic [7:0][15:0] ei;
    logic             eo;
  } vec_t;

  vec_t vecs [5];

  int sh_re_n [8] = '{256, 181, 0, -181, -256, -181, 0, 181};
  int sh_im_n [8] = '{0, -181, -256, -181, 0, 181, 256, 181};
  int sh_re_s [8] = '{32, 22, 0, -23, -32, -23, 0, 22};
  int sh_im_s [8] = '{0, -23, -32, -23, 0, 22, 32, 22};

  task automatic check(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int wrapw(input int v);
    logic signed [15:0] t;
    t = v[15:0];
    return int'(t);
  endfunction

  function automatic int mulc(input int a);
    int m, p;
    m = (a < 0) ? -a : a;
    p = (m * CC) >>> FRAC;
    return (a < 0) ? -p : p;
  endfunction

  function automatic int sumw(input int s, inout bit ov);
    if (s > 32767 || s < -32768) ov = 1'b1;
    return wrapw(s);
  endfunction

  function automatic int bfo(input int s, inout bit ov);
    if (s > 32767 || s < -32768) ov = 1'b1;
    if (SCALED != 0) return s >>> 1;
    return wrapw(s);
  endfunction

  function automatic int brev(input int n);
    return ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
  endfunction

  task automatic model(input int xr [8], input int xi [8],
                       output int yr [8], output int yi [8],
                       output int ovo);
    int r [8];
    int m [8];
    bit o;
    int span, k, lo, hi, hr, hm, s, d, ar, ai;
    o = 1'b0;
    for (int n = 0; n < 8; n++) begin
      r[brev(n)] = xr[n];
      m[brev(n)] = xi[n];
    end
    for (int st = 0; st < 3; st++) begin
      span = 1 << st;
      for (int g = 0; g < 8; g += 2 * span) begin
        for (int j = 0; j < span; j++) begin
          lo = g + j;
          hi = lo + span;
          k = j * 4 / span;
          hr = r[hi];
          hm = m[hi];
          if (k == 1 || k == 3) begin
            s = sumw(r[hi] + m[hi], o);
            d = sumw(m[hi] - r[hi], o);
            if (k == 1) begin
              hr = mulc(s);
              hm = mulc(d);
            end else begin
              hr = mulc(d);
              hm = wrapw(-mulc(s));
            end
          end else if (k == 2) begin
            hr = m[hi];
            hm = wrapw(-r[hi]);
          end
          ar = r[lo];
          ai = m[lo];
          r[lo] = bfo(ar + hr, o);
          m[lo] = bfo(ai + hm, o);
          r[hi] = bfo(ar - hr, o);
          m[hi] = bfo(ai - hm, o);
        end
      end
    end
    yr = r;
    yi = m;
    ovo = int'(o);
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input int n, input bit rnd);
    int w;
    for (int k = 0; k < n; k++) begin
      if (rnd) begin
        w = 0;
        while ($urandom_range(0, 2) == 0 && w < 5) begin
          bus.in_valid = 1'b0;
          @(negedge clk);
          w++;
        end
      end
      bus.in_valid = 1'b1;
      bus.in_real = 16'(sr[k]);
      bus.in_imag = 16'(si[k]);
      w = 0;
      while (!bus.in_ready && w < 200) begin
        @(negedge clk);
        w++;
      end
      if (!bus.in_ready) begin
        check("in_ready_wait", int'(bus.in_ready), 1);
        break;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic collect(input int nb, input bit rnd);
    int got, idle, ei;
    int pr, pi, px;
    bit pst;
    got = 0; idle = 0; ei = 0; pst = 1'b0;
    pr = 0; pi = 0; px = 0;
    while (got < nb && idle < 400) begin
      bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.out_valid) begin
        idle = 0;
        check("in_ready_in_out", int'(bus.in_ready), 0);
        if (pst) begin
          check("hold_re", int'(bus.out_real), pr);
          check("hold_im", int'(bus.out_imag), pi);
          check("hold_idx", int'(bus.out_index), px);
        end
        check("out_index", int'(bus.out_index), ei % 8);
        check("out_last", int'(bus.out_last), (ei % 8 == 7) ? 1 : 0);
        if (bus.out_ready) begin
          gt_re.push_back(int'(bus.out_real));
          gt_im.push_back(int'(bus.out_imag));
          gt_ov.push_back(int'(bus.out_ovf));
          got++;
          ei++;
          pst = 1'b0;
        end else begin
          pst = 1'b1;
          pr = int'(bus.out_real);
          pi = int'(bus.out_imag);
          px = int'(bus.out_index);
        end
      end else begin
        idle++;
        if (idle % 4 == 1)
          check("idle_zero", int'(bus.out_real) | int'(bus.out_imag), 0);
      end
      @(negedge clk);
    end
    if (got < nb) check("out_timeout", got, nb);
    bus.out_ready = 1'b0;
  endtask

  task automatic clear_got();
    gt_re.delete();
    gt_im.delete();
    gt_ov.delete();
  endtask

  task automatic run(input int nf, input bit rnd);
    clear_got();
    fork
      drive(nf * 8, rnd);
      collect(nf * 8, rnd);
    join
  endtask

  task automatic compare(input string tag, input int nf);
    int xr [8], xi [8], yr [8], yi [8];
    int ov;
    check({tag, "_count"}, gt_re.size(), nf * 8);
    if (gt_re.size() < nf * 8) return;
    for (int f = 0; f < nf; f++) begin
      for (int n = 0; n < 8; n++) begin
        xr[n] = sr[f * 8 + n];
        xi[n] = si[f * 8 + n];
      end
      model(xr, xi, yr, yi, ov);
      for (int k = 0; k < 8; k++) begin
        check($sformatf("%s_f%0d_re%0d", tag, f, k), gt_re[f * 8 + k], yr[k]);
        check($sformatf("%s_f%0d_im%0d", tag, f, k), gt_im[f * 8 + k], yi[k]);
        check($sformatf("%s_f%0d_ovf%0d", tag, f, k), gt_ov[f * 8 + k], ov);
      end
    end
  endtask

  task automatic rand_frames(input int nf, input int mag);
    for (int n = 0; n < nf * 8; n++) begin
      sr[n] = int'($urandom_range(0, 2 * mag)) - mag;
      si[n] = int'($urandom_range(0, 2 * mag)) - mag;
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog sim_time=%0t required=finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, seen, gd;
    bus.in_valid = 1'b0;
    bus.in_real = '0;
    bus.in_imag = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_real", int'(bus.out_real), 0);
    check("rst_out_imag", int'(bus.out_imag), 0);
    check("rst_out_index", int'(bus.out_index), 0);
    check("rst_out_last", int'(bus.out_last), 0);
    check("rst_out_ovf", int'(bus.out_ovf), 0);

    // vector table: impulse, DC, shifted impulse, overflow, zero
    for (int v = 0; v < 5; v++) vecs[v] = '0;
    vecs[0].xr[0] = 16'(256);
    for (int k = 0; k < 8; k++) vecs[0].er[k] = 16'(SCALED ? 32 : 256);
    for (int n = 0; n < 8; n++) vecs[1].xr[n] = 16'(256);
    vecs[1].er[0] = 16'(SCALED ? 256 : 2048);
    vecs[2].xr[1] = 16'(256);
    for (int k = 0; k < 8; k++) begin
      vecs[2].er[k] = 16'(SCALED ? sh_re_s[k] : sh_re_n[k]);
      vecs[2].ei[k] = 16'(SCALED ? sh_im_s[k] : sh_im_n[k]);
    end
    for (int n = 0; n < 8; n++) vecs[3].xr[n] = 16'h7fff;
    vecs[3].er[0] = 16'(SCALED ? 32767 : -8);
    vecs[3].eo = 1'b1;

    for (int v = 0; v < 5; v++) begin
      for (int n = 0; n < 8; n++) begin
        sr[n] = int'($signed(vecs[v].xr[n]));
        si[n] = int'($signed(vecs[v].xi[n]));
      end
      run(1, 1'b0);
      compare($sformatf("vec%0d", v), 1);
      if (gt_re.size() >= 8) begin
        for (int k = 0; k < 8; k++) begin
          check($sformatf("tab%0d_re%0d", v, k), gt_re[k],
                int'($signed(vecs[v].er[k])));
          check($sformatf("tab%0d_im%0d", v, k), gt_im[k],
                int'($signed(vecs[v].ei[k])));
          check($sformatf("tab%0d_ovf%0d", v, k), gt_ov[k],
                int'(vecs[v].eo));
        end
      end
    end

    // latency: three compute cycles with in_ready low
    rand_frames(1, 32767);
    clear_got();
    drive(8, 1'b0);
    lat = 0;
    while (!bus.out_valid && lat < 10) begin
      check("in_ready_compute", int'(bus.in_ready), 0);
      lat++;
      @(negedge clk);
    end
    check("latency", lat, 3);
    collect(8, 1'b0);
    compare("lat", 1);

    // reset mid-load, then mid-unload
    rand_frames(1, 2000);
    drive(5, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst1_in_ready", int'(bus.in_ready), 1);
    check("rst1_out_valid", int'(bus.out_valid), 0);
    rand_frames(1, 2000);
    drive(8, 1'b0);
    gd = 0;
    while (!bus.out_valid && gd < 10) begin
      gd++;
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    gd = 0;
    while (bus.out_index != 3'd3 && gd < 20) begin
      gd++;
      @(negedge clk);
    end
    check("rst2_at_idx", int'(bus.out_index), 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b0;
    seen = 0;
    repeat (20) begin
      if (bus.out_valid) seen++;
      @(negedge clk);
    end
    check("no_valid_after_rst", seen, 0);
    rand_frames(1, 32767);
    run(1, 1'b1);
    compare("post_rst", 1);

    // stress: 8 back-to-back frames with gaps and back-pressure
    rand_frames(8, 32767);
    for (int n = 32; n < 64; n++) begin
      sr[n] = sr[n] % 1000;
      si[n] = si[n] % 1000;
    end
    run(8, 1'b1);
    compare("stress", 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
